// File: rtl/generic_mult_pkg.sv
// generic_mult_pkg: shared types and helpers for the shift-and-add multiplier.
//   mult_state_e : FSM encoding (START, RUN, DONE)
//   clog2        : ceil(log2(v)), used to size the iteration counter
package generic_mult_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } mult_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/generic_mult_step.sv
// generic_mult_step: one combinational shift-and-add iteration.
//   p      : current product/multiplier register {acc, multiplier bits}
//   m      : captured multiplicand
//   p_next : {acc + (p[0] ? m : 0), p[W-1:1]}; the adder carry lands in the
//            top bit so no product bit is ever lost.
module generic_mult_step #(
    parameter int WIDTH = 128
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] p_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        p_next = {sum, p[WIDTH-1:1]};
    end

endmodule

// File: rtl/generic_mult.sv
// generic_mult: sequential unsigned shift-and-add multiplier, one iteration
// per clock. Full 2*WIDTH-bit product appears WIDTH edges after capture.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, aborts any operation
//   load  : start request, only honoured in DONE
//   in0   : multiplicand (unsigned)
//   in1   : multiplier (unsigned)
//   out   : product register (meaningful only while valid=1)
//   valid : out holds the full product of the last captured operands
// Optional: define GENERIC_MULT_ASSERT_EN to compile in simulation
// assertions (valid/state consistency, product check, counter bound).
module generic_mult
    import generic_mult_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    output logic [2*WIDTH-1:0] out,
    output logic               valid
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_e        state, state_n;
    logic               capture;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p, p_next;
    logic [CNT_W-1:0]   cnt;

    generic_mult_step #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .m      (m),
        .p_next (p_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= START;
        else     state <= state_n;
    end

    // START captures unconditionally so the block auto-runs after reset.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            START: begin
                capture = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_n = DONE;
            end
            DONE: begin
                if (load) begin
                    capture = 1'b1;
                    state_n = RUN;
                end
            end
            default: state_n = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p     <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (capture) begin
            m     <= in0;
            p     <= {{WIDTH{1'b0}}, in1};
            cnt   <= '0;
            valid <= 1'b0;
        end else if (state == RUN) begin
            p   <= p_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) valid <= 1'b1;
        end
    end

    assign out = p;

`ifdef GENERIC_MULT_ASSERT_EN
    logic [WIDTH-1:0] in1_shadow;

    always_ff @(posedge clk) begin
        if (!rst && capture) in1_shadow <= in1;
    end

    a_valid_state: assert property (@(posedge clk) disable iff (rst)
        (state != DONE) |-> !valid);

    a_product: assert property (@(posedge clk) disable iff (rst)
        (state == DONE) |->
            (out == ({{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, in1_shadow})));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt <= CNT_W'(WIDTH));
`endif

endmodule

// File: tb/tb_generic_mult.sv
module tb_generic_mult;

    localparam int W = 128;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cap;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [W-1:0]   in0, in1;
    logic [2*W-1:0] out;
    logic           valid;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    generic_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .in0   (in0),
        .in1   (in1),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on each rising valid, pop the oldest expectation and check
    // both the product and the capture-to-valid latency.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid cyc=%0d out=%h", cyc, out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out !== e.prod) begin
                    failures++;
                    $display("FAIL product got=%h exp=%h", out, e.prod);
                end
                checks++;
                if (cyc - e.cap != W) begin
                    failures++;
                    $display("FAIL latency got=%0d exp=%0d", cyc - e.cap, W);
                end
            end
        end
        prev_valid = valid;
    end

    task automatic chk(input string name, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout waiting for valid", name);
        end
    endtask

    // Called at a negedge while DONE: pulse load for one cycle.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expv, input bit push);
        exp_t e;
        in0  = a;
        in1  = b;
        load = 1'b1;
        if (push) begin
            e.prod = expv;
            e.cap  = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
        chk("valid_drop", {255'b0, valid}, '0);
    endtask

    initial begin
        exp_t e;
        rst  = 1'b1;
        load = 1'b0;
        in0  = W'(10);
        in1  = W'(12);
        repeat (3) @(negedge clk);
        chk("reset_valid", {255'b0, valid}, '0);
        chk("reset_out", out, '0);

        // Auto-start after reset release: 10*12.
        rst   = 1'b0;
        e.prod = 256'd120;
        e.cap  = cyc + 1;
        sb.push_back(e);
        wait_valid("auto_start");
        repeat (3) @(negedge clk);
        chk("done_hold_out", out, 256'd120);
        chk("done_hold_valid", {255'b0, valid}, 256'd1);

        start(W'(9999), W'(1234), 256'd12338766, 1);
        wait_valid("load_9999x1234");
        @(negedge clk);

        start({W{1'b1}}, {W{1'b1}},
              {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1}, 1);
        wait_valid("max_x_max");
        @(negedge clk);

        start(W'(0), W'(5), 256'd0, 1);
        wait_valid("zero_x_5");
        @(negedge clk);

        start(W'(7), W'(0), 256'd0, 1);
        wait_valid("7_x_zero");
        @(negedge clk);

        start({1'b1, 127'b0}, W'(2), {127'b0, 1'b1, 128'b0}, 1);
        wait_valid("2pow127_x_2");
        @(negedge clk);

        start(W'(1), {W{1'b1}}, {128'b0, {W{1'b1}}}, 1);
        wait_valid("1_x_max");
        @(negedge clk);

        // load during RUN is ignored; operand changes have no effect.
        start(W'(3), W'(5), 256'd15, 1);
        repeat (10) @(negedge clk);
        load = 1'b1;
        in0  = W'(100);
        in1  = W'(100);
        @(negedge clk);
        load = 1'b0;
        in0  = W'(77);
        wait_valid("load_in_run");
        @(negedge clk);

        // Reset mid-RUN aborts; auto-restart uses inputs present at restart.
        start(W'(11), W'(13), '0, 0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        in0 = W'(6);
        in1 = W'(7);
        @(negedge clk);
        chk("midrun_rst_valid", {255'b0, valid}, '0);
        chk("midrun_rst_out", out, '0);
        rst   = 1'b0;
        e.prod = 256'd42;
        e.cap  = cyc + 1;
        sb.push_back(e);
        wait_valid("restart_6x7");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 256'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
